// File: rtl/hicore_mem_pkg.sv
// Shared constants for the memory-queue drain: entry layout, size codes, FSM encoding.
// Entry layout is {is_store, unsigned, size[1:0], rd, addr, wdata}.
package hicore_mem_pkg;

  localparam int HICORE_MEM_AW     = 32;
  localparam int HICORE_MEM_XW     = 32;
  localparam int HICORE_MEM_RW     = 5;
  localparam int HICORE_MEM_INFO_W = 1 + 1 + 2 + HICORE_MEM_RW + HICORE_MEM_AW + HICORE_MEM_XW;

  localparam int HICORE_MEM_WDATA_LSB = 0;
  localparam int HICORE_MEM_ADDR_LSB  = HICORE_MEM_WDATA_LSB + HICORE_MEM_XW;
  localparam int HICORE_MEM_RD_LSB    = HICORE_MEM_ADDR_LSB + HICORE_MEM_AW;
  localparam int HICORE_MEM_SIZE_LSB  = HICORE_MEM_RD_LSB + HICORE_MEM_RW;
  localparam int HICORE_MEM_UNS_BIT   = HICORE_MEM_SIZE_LSB + 2;
  localparam int HICORE_MEM_STORE_BIT = HICORE_MEM_UNS_BIT + 1;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'd0,
    SZ_HALF     = 2'd1,
    SZ_WORD     = 2'd2,
    SZ_WORD_ALT = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_WB   = 2'd3
  } drain_state_e;

  // Half at an odd address, or any word-class size not on a word boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || (size[1] && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/hicore_mem_drain_if.sv
// Simple valid/ready data-memory bus: request channel plus response channel.
interface hicore_mem_drain_if #(
  parameter int AW = 32,
  parameter int XW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic [3:0]    req_wstrb;
  logic [XW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [XW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wstrb, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wstrb, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/hicore_mem_lane.sv
// Byte-lane steering: store strobe/data replication and load extract with sign/zero extension.
module hicore_mem_lane
  import hicore_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        uns,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every output gets a default before the case so no path leaves a latch.
  always_comb begin
    wstrb   = 4'b1111;
    wdata   = st_data;
    ld_data = ld_raw;
    ld_byte = ld_raw[8*lo +: 8];
    ld_half = lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (size)
      SZ_BYTE: begin
        wstrb   = 4'b0001 << lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{~uns & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        wstrb   = 4'b0011 << {lo[1], 1'b0};
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{~uns & ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hicore_mem_drain.sv
// Memory-queue drain: pops entries, runs one bus transaction at a time, presents writeback.
// Optional misalignment trap compiled in with `define HICORE_MEM_MISALIGN_CHK_EN.
module hicore_mem_drain
  import hicore_mem_pkg::*;
#(
  parameter  int AW = HICORE_MEM_AW,
  parameter  int XW = HICORE_MEM_XW,
  parameter  int RW = HICORE_MEM_RW,
  localparam int IW = HICORE_MEM_INFO_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  q_valid,
  output logic                  q_ready,
  input  logic                  q_cancel,
  input  logic [IW-1:0]         q_info,
  hicore_mem_drain_if.master    bus,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [RW-1:0]         wb_rd,
  output logic                  wb_wen,
  output logic [XW-1:0]         wb_data,
  output logic                  wb_err,
  output logic                  busy
);

  drain_state_e state, state_nxt;
  logic         kill;

  logic          e_store, e_uns;
  logic [1:0]    e_size;
  logic [RW-1:0] e_rd;
  logic [AW-1:0] e_addr;
  logic [XW-1:0] e_wdata;

  logic          r_err, r_wen;
  logic [XW-1:0] r_data;

  logic          in_store, in_uns;
  logic [1:0]    in_size;
  logic [RW-1:0] in_rd;
  logic [AW-1:0] in_addr;
  logic [XW-1:0] in_wdata;
  logic          take, misalign_hit;

  logic [3:0]    st_wstrb;
  logic [XW-1:0] st_wdata, ld_data;

  assign in_store = q_info[HICORE_MEM_STORE_BIT];
  assign in_uns   = q_info[HICORE_MEM_UNS_BIT];
  assign in_size  = q_info[HICORE_MEM_SIZE_LSB +: 2];
  assign in_rd    = q_info[HICORE_MEM_RD_LSB +: RW];
  assign in_addr  = q_info[HICORE_MEM_ADDR_LSB +: AW];
  assign in_wdata = q_info[HICORE_MEM_WDATA_LSB +: XW];

  assign take = (state == ST_IDLE) && q_valid && !q_cancel;

`ifdef HICORE_MEM_MISALIGN_CHK_EN
  assign misalign_hit = misaligned(in_size, in_addr[1:0]);
`else
  assign misalign_hit = 1'b0;
`endif

  hicore_mem_lane u_lane (
    .size    (e_size),
    .lo      (e_addr[1:0]),
    .uns     (e_uns),
    .st_data (e_wdata),
    .ld_raw  (bus.rsp_rdata),
    .wstrb   (st_wstrb),
    .wdata   (st_wdata),
    .ld_data (ld_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (take)             state_nxt = misalign_hit ? ST_WB : ST_REQ;
      ST_REQ:  if (bus.req_ready)    state_nxt = ST_RSP;
      // A flush seen together with the response still suppresses the writeback.
      ST_RSP:  if (bus.rsp_valid)    state_nxt = (kill || flush) ? ST_IDLE : ST_WB;
      ST_WB:   if (wb_ready || flush) state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_IDLE)
        kill <= 1'b0;
      else if (flush && ((state == ST_REQ) || (state == ST_RSP)))
        kill <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_store <= 1'b0;
      e_uns   <= 1'b0;
      e_size  <= 2'b00;
      e_rd    <= '0;
      e_addr  <= '0;
      e_wdata <= '0;
      r_err   <= 1'b0;
      r_wen   <= 1'b0;
      r_data  <= '0;
    end else begin
      if (take) begin
        e_store <= in_store;
        e_uns   <= in_uns;
        e_size  <= in_size;
        e_rd    <= in_rd;
        e_addr  <= in_addr;
        e_wdata <= in_wdata;
        if (misalign_hit) begin
          r_err  <= 1'b1;
          r_wen  <= 1'b0;
          r_data <= XW'(in_addr);
        end
      end
      if ((state == ST_RSP) && bus.rsp_valid) begin
        r_err  <= bus.rsp_err;
        r_wen  <= ~bus.rsp_err & ~e_store;
        r_data <= (bus.rsp_err || e_store) ? '0 : ld_data;
      end
    end
  end

  assign q_ready       = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);

  assign bus.req_valid = (state == ST_REQ);
  assign bus.req_addr  = bus.req_valid ? {e_addr[AW-1:2], 2'b00} : '0;
  assign bus.req_we    = bus.req_valid & e_store;
  assign bus.req_wstrb = bus.req_we ? st_wstrb : 4'b0000;
  assign bus.req_wdata = bus.req_we ? st_wdata : '0;
  assign bus.rsp_ready = (state == ST_RSP);

  assign wb_valid      = (state == ST_WB);
  assign wb_rd         = wb_valid ? e_rd : '0;
  assign wb_wen        = wb_valid & r_wen;
  assign wb_data       = wb_valid ? r_data : '0;
  assign wb_err        = wb_valid & r_err;

endmodule

// File: tb/tb_hicore_mem_drain.sv
// Scoreboard bench for hicore_mem_drain: expected bus requests and writebacks are queued
// at stimulus time and popped by a monitor when the DUT handshakes.
module tb_hicore_mem_drain;
  import hicore_mem_pkg::*;

  localparam int IW = HICORE_MEM_INFO_W;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } exp_req_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic        err;
  } exp_wb_t;

  logic          clk, rst, flush;
  logic          q_valid, q_ready, q_cancel;
  logic [IW-1:0] q_info;
  logic          wb_valid, wb_ready, wb_wen, wb_err, busy;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;

  hicore_mem_drain_if #(.AW(32), .XW(32)) bus ();

  hicore_mem_drain dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .q_cancel (q_cancel),
    .q_info   (q_info),
    .bus      (bus),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_rd    (wb_rd),
    .wb_wen   (wb_wen),
    .wb_data  (wb_data),
    .wb_err   (wb_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_req_t req_q[$];
  exp_wb_t  wb_q[$];
  int n_tests, n_fail;
  int n_req, n_rsp, n_wb_cycles, n_req_extra, n_wb_extra;
  logic [31:0] mem_rdata;
  logic        mem_err;
  int          rsp_delay;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic st, input logic uns, input logic [1:0] sz,
                                       input logic [4:0] rd, input logic [31:0] a,
                                       input logic [31:0] wd);
    return {st, uns, sz, rd, a, wd};
  endfunction

  // Monitor: samples mid-low-phase, so a handshake seen here completes at the next posedge.
  initial begin
    exp_req_t r;
    exp_wb_t  w;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        if (bus.req_valid && bus.req_ready) begin
          n_req++;
          if (req_q.size() == 0) n_req_extra++;
          else begin
            r = req_q.pop_front();
            check("req_addr", bus.req_addr, r.addr);
            check("req_we", 32'(bus.req_we), 32'(r.we));
            if (r.we) begin
              check("req_wstrb", 32'(bus.req_wstrb), 32'(r.wstrb));
              check("req_wdata", bus.req_wdata, r.wdata);
            end
          end
        end
        if (bus.rsp_valid && bus.rsp_ready) n_rsp++;
        if (wb_valid) n_wb_cycles++;
        if (wb_valid && wb_ready) begin
          if (wb_q.size() == 0) n_wb_extra++;
          else begin
            w = wb_q.pop_front();
            check("wb_rd", 32'(wb_rd), 32'(w.rd));
            check("wb_wen", 32'(wb_wen), 32'(w.wen));
            check("wb_data", wb_data, w.data);
            check("wb_err", 32'(wb_err), 32'(w.err));
          end
        end
      end
    end
  end

  // Memory responder: answers each accepted request after rsp_delay extra cycles.
  initial begin
    bus.req_ready = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.req_valid && bus.req_ready) begin
        repeat (1 + rsp_delay) @(negedge clk);
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = mem_rdata;
        bus.rsp_err   = mem_err;
        @(negedge clk);
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_entry(input logic [IW-1:0] info, input logic [31:0] rdata,
                           input logic err, input int dly, output int lat);
    @(negedge clk);
    mem_rdata = rdata;
    mem_err   = err;
    rsp_delay = dly;
    q_info    = info;
    q_cancel  = 1'b0;
    q_valid   = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    q_info  = '0;
    lat = 1;
    while (!wb_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    wait_idle();
  endtask

  task automatic do_case(input string tag, input logic [IW-1:0] info, input logic [31:0] rdata,
                         input logic err, input exp_req_t er, input exp_wb_t ew);
    int lat;
    req_q.push_back(er);
    wb_q.push_back(ew);
    run_entry(info, rdata, err, 0, lat);
    check({tag, "_latency"}, 32'(lat), 32'd3);
  endtask

  initial begin
    int lat, req0, rsp0, wbc0, n;
    n_tests = 0; n_fail = 0;
    n_req = 0; n_rsp = 0; n_wb_cycles = 0; n_req_extra = 0; n_wb_extra = 0;
    mem_rdata = '0; mem_err = 1'b0; rsp_delay = 0;
    rst = 1'b1; flush = 1'b0; q_valid = 1'b0; q_cancel = 1'b0; q_info = '0; wb_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_q_ready", 32'(q_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_valid", 32'(bus.req_valid), 32'd0);
    check("rst_req_addr", bus.req_addr, 32'd0);
    check("rst_req_wstrb", 32'(bus.req_wstrb), 32'd0);
    check("rst_rsp_ready", 32'(bus.rsp_ready), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;

    do_case("ld_word", mk(0, 0, 2'd2, 5'd5, 32'h100, 32'h0), 32'hDEADBEEF, 1'b0,
            '{32'h100, 1'b0, 4'h0, 32'h0}, '{5'd5, 1'b1, 32'hDEADBEEF, 1'b0});
    do_case("ld_sbyte", mk(0, 0, 2'd0, 5'd7, 32'h103, 32'h0), 32'h80123456, 1'b0,
            '{32'h100, 1'b0, 4'h0, 32'h0}, '{5'd7, 1'b1, 32'hFFFFFF80, 1'b0});
    do_case("ld_ubyte", mk(0, 1, 2'd0, 5'd7, 32'h103, 32'h0), 32'h80123456, 1'b0,
            '{32'h100, 1'b0, 4'h0, 32'h0}, '{5'd7, 1'b1, 32'h00000080, 1'b0});
    do_case("st_half", mk(1, 0, 2'd1, 5'd3, 32'h102, 32'h00001234), 32'h55555555, 1'b0,
            '{32'h100, 1'b1, 4'b1100, 32'h12341234}, '{5'd3, 1'b0, 32'h0, 1'b0});
    do_case("ld_shalf_hi", mk(0, 0, 2'd1, 5'd9, 32'h102, 32'h0), 32'h80017FFF, 1'b0,
            '{32'h100, 1'b0, 4'h0, 32'h0}, '{5'd9, 1'b1, 32'hFFFF8001, 1'b0});
    do_case("ld_shalf_lo", mk(0, 0, 2'd1, 5'd9, 32'h100, 32'h0), 32'h80017FFF, 1'b0,
            '{32'h100, 1'b0, 4'h0, 32'h0}, '{5'd9, 1'b1, 32'h00007FFF, 1'b0});
    do_case("st_byte", mk(1, 0, 2'd0, 5'd1, 32'h101, 32'h000000AB), 32'h0, 1'b0,
            '{32'h100, 1'b1, 4'b0010, 32'hABABABAB}, '{5'd1, 1'b0, 32'h0, 1'b0});
    do_case("st_word", mk(1, 0, 2'd2, 5'd2, 32'h200, 32'hCAFEF00D), 32'h0, 1'b0,
            '{32'h200, 1'b1, 4'b1111, 32'hCAFEF00D}, '{5'd2, 1'b0, 32'h0, 1'b0});
    do_case("ld_err", mk(0, 0, 2'd2, 5'd12, 32'h300, 32'h0), 32'h12345678, 1'b1,
            '{32'h300, 1'b0, 4'h0, 32'h0}, '{5'd12, 1'b0, 32'h0, 1'b1});
    do_case("ld_size3", mk(0, 0, 2'd3, 5'd31, 32'h104, 32'h0), 32'h0BADF00D, 1'b0,
            '{32'h104, 1'b0, 4'h0, 32'h0}, '{5'd31, 1'b1, 32'h0BADF00D, 1'b0});

    // Cancelled entries: one pop per cycle, no bus traffic.
    req0 = n_req;
    @(negedge clk);
    q_info = mk(0, 0, 2'd2, 5'd4, 32'h600, 32'h0);
    q_valid = 1'b1; q_cancel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("cancel_pop", 32'(q_ready), 32'd1);
      check("cancel_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    q_valid = 1'b0; q_cancel = 1'b0;
    repeat (4) @(negedge clk);
    check("cancel_no_bus", 32'(n_req), 32'(req0));

    // Flush during RSP with a response two cycles late.
    rsp0 = n_rsp; wbc0 = n_wb_cycles;
    req_q.push_back('{32'h400, 1'b0, 4'h0, 32'h0});
    @(negedge clk);
    mem_rdata = 32'h11111111; mem_err = 1'b0; rsp_delay = 2;
    q_info = mk(0, 0, 2'd2, 5'd6, 32'h400, 32'h0); q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    @(negedge clk);
    check("flush_rsp_state", 32'(bus.rsp_ready), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (6) @(negedge clk);
    check("flush_rsp_absorbed", 32'(n_rsp), 32'(rsp0 + 1));
    check("flush_rsp_no_wb", 32'(n_wb_cycles), 32'(wbc0));
    check("flush_rsp_busy", 32'(busy), 32'd0);
    rsp_delay = 0;

    // Flush while writeback is stalled: wb_valid drops next cycle.
    wb_ready = 1'b0;
    req_q.push_back('{32'h500, 1'b0, 4'h0, 32'h0});
    @(negedge clk);
    mem_rdata = 32'h22222222;
    q_info = mk(0, 0, 2'd2, 5'd8, 32'h500, 32'h0); q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    n = 0;
    while (!wb_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("flush_wb_reached", 32'(wb_valid), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_wb_drop", 32'(wb_valid), 32'd0);
    check("flush_wb_busy", 32'(busy), 32'd0);
    wb_ready = 1'b1;

    // Misaligned word load at 0x101.
    req0 = n_req;
`ifdef HICORE_MEM_MISALIGN_CHK_EN
    wb_q.push_back('{5'd10, 1'b0, 32'h101, 1'b1});
    run_entry(mk(0, 0, 2'd2, 5'd10, 32'h101, 32'h0), 32'h33333333, 1'b0, 0, lat);
    check("misalign_latency", 32'(lat), 32'd1);
    check("misalign_no_bus", 32'(n_req), 32'(req0));
`else
    req_q.push_back('{32'h100, 1'b0, 4'h0, 32'h0});
    wb_q.push_back('{5'd10, 1'b1, 32'h33333333, 1'b0});
    run_entry(mk(0, 0, 2'd2, 5'd10, 32'h101, 32'h0), 32'h33333333, 1'b0, 0, lat);
    check("misalign_latency", 32'(lat), 32'd3);
    check("misalign_bus", 32'(n_req), 32'(req0 + 1));
`endif

    repeat (4) @(negedge clk);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("wb_q_drained", 32'(wb_q.size()), 32'd0);
    check("req_unexpected", 32'(n_req_extra), 32'd0);
    check("wb_unexpected", 32'(n_wb_extra), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
